// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;

  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding comparator: picks the Memory, Writeback or
// register-file value for one Execute-stage ALU source. Purely combinational.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] ra_e_i,
  input  logic [REG_ADDR_W-1:0] wa_m_i,
  input  logic [REG_ADDR_W-1:0] wa_w_i,
  input  logic                  reg_write_m_i,
  input  logic                  reg_write_w_i,
  output fwd_sel_t              fwd_o
);

  // Memory is the younger result, so it wins when both stages match.
  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (ra_e_i == wa_m_i)) begin
      fwd_o = FWD_MEM;
    end else if (reg_write_w_i && (ra_e_i == wa_w_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: combinational forwarding, stall and flush
// controls, plus saturating stall/flush/forward event counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] RA1D,
  input  logic [REG_ADDR_W-1:0] RA2D,
  input  logic [REG_ADDR_W-1:0] RA1E,
  input  logic [REG_ADDR_W-1:0] RA2E,
  input  logic [REG_ADDR_W-1:0] WA3E,
  input  logic [REG_ADDR_W-1:0] WA3M,
  input  logic [REG_ADDR_W-1:0] WA3W,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  PCSrcD,
  input  logic                  PCSrcE,
  input  logic                  PCSrcM,
  input  logic                  PCSrcW,
  input  logic                  BranchTakenE,
  input  logic                  cnt_clr,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      fwd_cnt
);

  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;

  hazard_fwd_sel u_fwd_a (
    .ra_e_i        (RA1E),
    .wa_m_i        (WA3M),
    .wa_w_i        (WA3W),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .ra_e_i        (RA2E),
    .wa_m_i        (WA3M),
    .wa_w_i        (WA3W),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (fwd_b)
  );

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  logic ldr_stall;
  logic pc_wr_pending_f;

  assign ldr_stall       = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
  assign pc_wr_pending_f = PCSrcD || PCSrcE || PCSrcM;

  // A load-use stall coinciding with a taken branch asserts all four: the
  // flush discards the wrong-path work while the stall still holds F/D.
  assign StallF = ldr_stall || pc_wr_pending_f;
  assign StallD = ldr_stall;
  assign FlushD = pc_wr_pending_f || PCSrcW || BranchTakenE;
  assign FlushE = ldr_stall || BranchTakenE;

  logic stall_ev;
  logic flush_ev;
  logic fwd_ev;

  assign stall_ev = StallF || StallD;
  assign flush_ev = FlushD || FlushE;
  assign fwd_ev   = (fwd_a != FWD_RF) || (fwd_b != FWD_RF);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             ev);
    return (ev && !(&c)) ? c + CNT_W'(1) : c;
  endfunction

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q,   fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
      fwd_cnt_d   = '0;
    end else begin
      stall_cnt_d = sat_inc(stall_cnt_q, stall_ev);
      flush_cnt_d = sat_inc(flush_cnt_q, flush_ev);
      fwd_cnt_d   = sat_inc(fwd_cnt_q, fwd_ev);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: table of hazard vectors through a scoreboard queue,
// a counter model, and hand sequences for clear, reset and saturation.
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, cnt_clr;

  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [15:0] stall_cnt, flush_cnt, fwd_cnt;

  logic [1:0] s_ForwardAE, s_ForwardBE;
  logic       s_StallF, s_StallD, s_FlushD, s_FlushE;
  logic [3:0] s_stall_cnt, s_flush_cnt, s_fwd_cnt;

  hazard_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .cnt_clr(cnt_clr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fwd_cnt(fwd_cnt)
  );

  // Narrow-counter twin shares all inputs; it exposes saturation quickly.
  hazard_unit #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .cnt_clr(cnt_clr),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
    .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .fwd_cnt(s_fwd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       sf;
    logic       sd;
    logic       fd;
    logic       fe;
  } exp_t;

  typedef struct {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic       rwm, rww, m2r, pcd, pce, pcm, pcw, bte;
    exp_t       exp;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t sb[$];
  int   m_stall, m_flush, m_fwd;
  int   ms_stall, ms_flush, ms_fwd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w,
    input logic rwm, rww, m2r, pcd, pce, pcm, pcw, bte,
    input logic [1:0] fa, fb, input logic sf, sd, fd, fe);
    vec_t v;
    v.ra1d = ra1d; v.ra2d = ra2d; v.ra1e = ra1e; v.ra2e = ra2e;
    v.wa3e = wa3e; v.wa3m = wa3m; v.wa3w = wa3w;
    v.rwm = rwm; v.rww = rww; v.m2r = m2r;
    v.pcd = pcd; v.pce = pce; v.pcm = pcm; v.pcw = pcw; v.bte = bte;
    v.exp = '{fa: fa, fb: fb, sf: sf, sd: sd, fd: fd, fe: fe};
    return v;
  endfunction

  task automatic apply(input vec_t v);
    RA1D = v.ra1d; RA2D = v.ra2d; RA1E = v.ra1e; RA2E = v.ra2e;
    WA3E = v.wa3e; WA3M = v.wa3m; WA3W = v.wa3w;
    RegWriteM = v.rwm; RegWriteW = v.rww; MemtoRegE = v.m2r;
    PCSrcD = v.pcd; PCSrcE = v.pce; PCSrcM = v.pcm; PCSrcW = v.pcw;
    BranchTakenE = v.bte;
  endtask

  task automatic chk_hazards(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " ForwardAE"}, 32'(ForwardAE), 32'(e.fa));
      chk({tag, " ForwardBE"}, 32'(ForwardBE), 32'(e.fb));
      chk({tag, " StallF"}, 32'(StallF), 32'(e.sf));
      chk({tag, " StallD"}, 32'(StallD), 32'(e.sd));
      chk({tag, " FlushD"}, 32'(FlushD), 32'(e.fd));
      chk({tag, " FlushE"}, 32'(FlushE), 32'(e.fe));
    end
  endtask

  function automatic int sat(input int c, input logic ev, input int maxv);
    return (ev && c < maxv) ? c + 1 : c;
  endfunction

  task automatic model_edge(input exp_t e);
    logic se, fe_, we;
    se  = e.sf | e.sd;
    fe_ = e.fd | e.fe;
    we  = (e.fa != 2'b00) | (e.fb != 2'b00);
    m_stall  = sat(m_stall, se, 16'hFFFF);
    m_flush  = sat(m_flush, fe_, 16'hFFFF);
    m_fwd    = sat(m_fwd, we, 16'hFFFF);
    ms_stall = sat(ms_stall, se, 15);
    ms_flush = sat(ms_flush, fe_, 15);
    ms_fwd   = sat(ms_fwd, we, 15);
  endtask

  task automatic model_clear();
    m_stall = 0; m_flush = 0; m_fwd = 0;
    ms_stall = 0; ms_flush = 0; ms_fwd = 0;
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, " stall_cnt"}, 32'(stall_cnt), m_stall);
    chk({tag, " flush_cnt"}, 32'(flush_cnt), m_flush);
    chk({tag, " fwd_cnt"}, 32'(fwd_cnt), m_fwd);
    chk({tag, " small stall_cnt"}, 32'(s_stall_cnt), ms_stall);
    chk({tag, " small flush_cnt"}, 32'(s_flush_cnt), ms_flush);
    chk({tag, " small fwd_cnt"}, 32'(s_fwd_cnt), ms_fwd);
  endtask

  vec_t tbl[$];
  vec_t idle_v, lu_v;

  initial begin
    //           ra1d ra2d ra1e ra2e wa3e wa3m wa3w rwm rww m2r pcd pce pcm pcw bte  fa     fb    sf sd fd fe
    idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    lu_v   = mk(0, 5, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 1);
    tbl.push_back(idle_v);
    tbl.push_back(mk(0, 0, 3, 7, 0, 3, 3, 1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 7, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 7, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4, 4, 0, 9, 4, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0));
    tbl.push_back(mk(2, 5, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 1));
    tbl.push_back(mk(2, 5, 0, 0, 6, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(5, 2, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 1));
    tbl.push_back(mk(5, 2, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0));
    tbl.push_back(mk(0, 5, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 1, 1, 1));

    // Reset state, and hazard outputs live while rst is held.
    rst = 1'b1; cnt_clr = 1'b0;
    apply(idle_v);
    model_clear();
    #1;
    sb.push_back(idle_v.exp);
    chk_hazards("reset idle");
    chk_cnts("reset");
    apply(lu_v);
    sb.push_back(lu_v.exp);
    #1;
    chk_hazards("reset loaduse");
    repeat (2) @(posedge clk);
    #1;
    chk_cnts("reset held");
    @(negedge clk);
    apply(idle_v);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i]);
      sb.push_back(tbl[i].exp);
      #1;
      chk_hazards($sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      model_edge(tbl[i].exp);
      chk_cnts($sformatf("vec%0d", i));
    end

    // Clear wins over a concurrent increment.
    @(negedge clk);
    apply(lu_v);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    chk_cnts("clear");
    @(negedge clk);
    cnt_clr = 1'b0;

    // Stall held for three cycles.
    repeat (3) begin
      @(posedge clk);
      #1;
      model_edge(lu_v.exp);
    end
    chk_cnts("stall x3");
    chk("stall x3 value", 32'(stall_cnt), 32'd3);

    // Asynchronous reset between edges.
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    chk_cnts("async rst");
    chk("async rst StallD", 32'(StallD), 32'd1);
    @(posedge clk);
    #1;
    chk_cnts("rst held edge");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_edge(lu_v.exp);
    chk_cnts("resume");
    chk("resume value", 32'(stall_cnt), 32'd1);

    // Saturation of the narrow twin while the wide one keeps counting.
    repeat (20) begin
      @(posedge clk);
      #1;
      model_edge(lu_v.exp);
    end
    chk_cnts("saturate");
    chk("saturate small", 32'(s_stall_cnt), 32'hF);
    chk("saturate wide", 32'(stall_cnt), 32'd21);

    @(negedge clk);
    apply(idle_v);
    @(posedge clk);
    #1;
    model_edge(idle_v.exp);
    chk_cnts("idle after sat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard unit for the five-stage (F/D/E/M/W) vector-processor core. Combinationally resolves data hazards by selecting forwarding sources for both Execute-stage ALU operands. Detects load-use hazards and PC-write control hazards, driving stall and flush controls to the fetch, decode and execute pipeline registers. Keeps saturating event counters for performance debug.

## Interface
Parameters:
- CNT_W, default 16: width of each event counter.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- RA1D, RA2D  in  4  source register addresses in Decode.
- RA1E, RA2E  in  4  source register addresses in Execute.
- WA3E, WA3M, WA3W  in  4  destination addresses in Execute, Memory and Writeback.
- RegWriteM, RegWriteW  in  1  register-write enables in Memory and Writeback.
- MemtoRegE  in  1  the instruction in Execute is a load.
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  the instruction in that stage writes the PC.
- BranchTakenE  in  1  branch resolved taken in Execute.
- cnt_clr  in  1  synchronous clear of all counters.
- ForwardAE, ForwardBE  out  2  operand source select for SrcA and SrcB.
- StallF, StallD  out  1  hold the fetch and decode pipeline registers.
- FlushD, FlushE  out  1  bubble the decode and execute pipeline registers.
- stall_cnt, flush_cnt, fwd_cnt  out  CNT_W  event counters.

## Operation
- Forwarding (ForwardAE from RA1E; ForwardBE identical using RA2E):
  - 2'b10 (Memory result) if RA1E==WA3M and RegWriteM.
  - Otherwise 2'b01 (Writeback result) if RA1E==WA3W and RegWriteW.
  - Otherwise 2'b00 (register file).
  - Memory has priority when both stages match.
  - Register 0 is a normal register and receives no special treatment.
- Load-use: ldrStall = MemtoRegE and (RA1D==WA3E or RA2D==WA3E).
- PCWrPendingF = PCSrcD or PCSrcE or PCSrcM.
- StallF = ldrStall or PCWrPendingF.
- StallD = ldrStall.
- FlushD = PCWrPendingF or PCSrcW or BranchTakenE.
- FlushE = ldrStall or BranchTakenE.
- Counters, each saturating at all-ones:
  - stall_cnt increments on any cycle with StallF or StallD high.
  - flush_cnt increments on any cycle with FlushD or FlushE high.
  - fwd_cnt increments on any cycle with ForwardAE!=0 or ForwardBE!=0.
  - Each counter increments by at most 1 per cycle.
- X or unknown inputs are not filtered; behaviour under X inputs is undefined.

## Timing
- All hazard outputs are purely combinational from current inputs, with zero latency.
- Hazard outputs are unaffected by rst and clk.
- With all enables low, every hazard output is 0.
- Counters update on the rising edge of clk.
- Counters reset asynchronously to 0 while rst is high.
- cnt_clr has priority over increment; the counter reads 0 after the clearing edge.
- rst asserted mid-count clears the counters immediately. Counting resumes on the first edge after rst deasserts.
- Simultaneous load-use and taken branch: StallF, StallD, FlushD and FlushE are all 1. The flush takes effect and the stall holds F/D.

## Structure
- Shared package hazard_pkg holds:
  - fwd_sel_t, a 2-bit enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_ADDR_W=4.
- Sub-module hazard_fwd_sel is the per-operand forwarding comparator. It is instantiated twice, once for A and once for B.
- Stall/flush logic and the counters live in the top-level hazard_unit.

## Test plan
- RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=2'b10 (Memory priority).
- RA1E=1, WA3M=0, WA3W=1, RegWriteM=0, RegWriteW=1 -> ForwardAE=2'b01. Then RegWriteW=0 -> 2'b00.
- RA2E=1, WA3M=1, RegWriteM=1 -> ForwardBE=2'b10. Then RA2E=0, WA3M=0, WA3W=0, RegWriteM=0, RegWriteW=0 -> ForwardBE=2'b00.
- MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=1, StallD=1, FlushE=1, FlushD=0. Then WA3E=6 -> all 0.
- PCSrcE=1 -> StallF=1, FlushD=1, StallD=0. BranchTakenE=1 alone -> FlushD=1, FlushE=1.
- Counters:
  - Hold a stall for 3 cycles -> stall_cnt=3.
  - cnt_clr for 1 cycle -> 0.
  - rst mid-run -> all counters 0 asynchronously.
  - Preload near max -> saturates at 16'hFFFF.
